// File: rtl/iomem_router_if.sv
// rtl/iomem_router_if.sv - iomem request side and four-slot peripheral side of the router
interface iomem_router_if;
  // SoC-facing iomem request
  logic         m_valid;
  logic         m_ready;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata;
  // Slot-facing request, one valid/ready pair per slot
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;

  // Router view: serves the SoC request, drives the slots
  modport slave (
    input  m_valid, m_wstrb, m_addr, m_wdata,
    output m_ready, m_rdata,
    output s_valid, s_wstrb, s_addr, s_wdata,
    input  s_ready, s_rdata
  );

  // Environment view: SoC master plus the slot responders
  modport master (
    output m_valid, m_wstrb, m_addr, m_wdata,
    input  m_ready, m_rdata,
    input  s_valid, s_wstrb, s_addr, s_wdata,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/iomem_router.sv
// rtl/iomem_router.sv - page-decoded iomem router with timeout and sticky error flags
module iomem_router #(
  parameter logic [7:0]  BASE_PAGE = 8'h03,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                resetn,
  iomem_router_if.slave       bus,
  input  logic                err_clr,
  output logic                err_unmapped,
  output logic                err_timeout,
  output logic [31:0]         err_addr
);

  typedef enum logic [1:0] {IDLE, BUSY, UNMAP, DONE} state_t;

  // Counter value on which the slot is declared dead
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic        m_ready_q, m_ready_d;
  logic [31:0] m_rdata_q, m_rdata_d;
  logic [3:0]  s_valid_q, s_valid_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic        err_unm_q, err_unm_d;
  logic        err_to_q, err_to_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [7:0]  idx;

  // Slot index relative to the base page; 8-bit wrap lets the map straddle page 00
  assign idx = bus.m_addr[31:24] - BASE_PAGE;

  // Next-state and next-output logic for the request sequencer
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    m_ready_d  = m_ready_q;
    m_rdata_d  = m_rdata_q;
    s_valid_d  = s_valid_q;
    s_wstrb_d  = s_wstrb_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    err_addr_d = err_addr_q;
    // A clear loses against an error event later in this block
    err_unm_d  = err_clr ? 1'b0 : err_unm_q;
    err_to_d   = err_clr ? 1'b0 : err_to_q;

    case (state_q)
      IDLE: begin
        if (bus.m_valid) begin
          s_addr_d  = bus.m_addr;
          s_wdata_d = bus.m_wdata;
          s_wstrb_d = bus.m_wstrb;
          if (idx < 8'd4) begin
            sel_d     = idx[1:0];
            s_valid_d = 4'b0001 << idx[1:0];
            cnt_d     = 16'd0;
            state_d   = BUSY;
          end else begin
            state_d = UNMAP;
          end
        end
      end
      BUSY: begin
        // A late answer on the expiry cycle still counts as a normal completion
        if (bus.s_ready[sel_q]) begin
          m_rdata_d = bus.s_rdata[{sel_q, 5'b0} +: 32];
          m_ready_d = 1'b1;
          s_valid_d = 4'b0000;
          state_d   = DONE;
        end else if (cnt_q == TO_LAST) begin
          m_rdata_d  = ERR_RDATA;
          m_ready_d  = 1'b1;
          s_valid_d  = 4'b0000;
          err_to_d   = 1'b1;
          err_addr_d = s_addr_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      UNMAP: begin
        m_rdata_d  = 32'd0;
        m_ready_d  = 1'b1;
        err_unm_d  = 1'b1;
        err_addr_d = s_addr_q;
        state_d    = DONE;
      end
      DONE: begin
        // m_valid is deliberately not looked at here so the SoC can retire its request
        m_ready_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops s_valid without waiting for a clock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      cnt_q      <= 16'd0;
      m_ready_q  <= 1'b0;
      m_rdata_q  <= 32'd0;
      s_valid_q  <= 4'b0000;
      s_wstrb_q  <= 4'b0000;
      s_addr_q   <= 32'd0;
      s_wdata_q  <= 32'd0;
      err_unm_q  <= 1'b0;
      err_to_q   <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      m_ready_q  <= m_ready_d;
      m_rdata_q  <= m_rdata_d;
      s_valid_q  <= s_valid_d;
      s_wstrb_q  <= s_wstrb_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      err_unm_q  <= err_unm_d;
      err_to_q   <= err_to_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.m_ready   = m_ready_q;
  assign bus.m_rdata   = m_rdata_q;
  assign bus.s_valid   = s_valid_q;
  assign bus.s_wstrb   = s_wstrb_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wdata   = s_wdata_q;
  assign err_unmapped  = err_unm_q;
  assign err_timeout   = err_to_q;
  assign err_addr      = err_addr_q;

endmodule
